// File: rtl/dumbrv_spi_arb.sv
// Shares the byte-wide SPI memory controller between the fetch and load/store ports.
// Define DUMBRV_SPI_ARB_RR_EN for round-robin arbitration; otherwise the data port has fixed priority.
module dumbrv_spi_arb #(
  parameter int FETCH_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [15:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_data_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [1:0]  d_size_i,
  input  logic [15:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_ack_o,
  output logic [31:0] d_rdata_o,
  output logic        m_valid_o,
  output logic        m_iswr_o,
  output logic [15:0] m_addr_o,
  output logic [7:0]  m_data_o,
  input  logic        m_done_i,
  input  logic [7:0]  m_data_i
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_GAP = 2'd2} state_t;

  // Any FETCH_BYTES value other than 2 is treated as a full-word fetch.
  localparam logic [1:0] FETCH_LAST = (FETCH_BYTES == 2) ? 2'd1 : 2'd3;

  state_t      state_r, state_s;
  logic        owner_data_r, owner_data_s;
  logic        iswr_r, iswr_s;
  logic [15:0] base_r, base_s;
  logic [1:0]  last_r, last_s;
  logic [1:0]  k_r, k_s;
  logic [31:0] wdata_r, wdata_s;
  logic [31:0] rdata_r, rdata_s;
  logic        m_valid_s, m_iswr_s;
  logic [15:0] m_addr_s;
  logic [7:0]  m_data_s;
  logic        if_ack_s, d_ack_s;
  logic [31:0] if_data_s, d_rdata_s;
  logic        grant_data_s;

  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    byte_lane = word[7:0];
      2'd1:    byte_lane = word[15:8];
      2'd2:    byte_lane = word[23:16];
      default: byte_lane = word[31:24];
    endcase
  endfunction

  function automatic logic [31:0] merge_byte(input logic [31:0] word, input logic [1:0] idx,
                                             input logic [7:0] b);
    merge_byte = word;
    case (idx)
      2'd0:    merge_byte[7:0]   = b;
      2'd1:    merge_byte[15:8]  = b;
      2'd2:    merge_byte[23:16] = b;
      default: merge_byte[31:24] = b;
    endcase
  endfunction

  function automatic logic [1:0] data_last(input logic [1:0] size);
    case (size)
      2'd0:    data_last = 2'd0;
      2'd1:    data_last = 2'd1;
      default: data_last = 2'd3;
    endcase
  endfunction

`ifdef DUMBRV_SPI_ARB_RR_EN
  logic rr_data_next_r;

  assign grant_data_s = d_req_i & (~if_req_i | rr_data_next_r);

  // Round-robin pointer: after each grant the other port becomes preferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_data_next_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && (if_req_i || d_req_i)) begin
      rr_data_next_r <= ~grant_data_s;
    end else begin
      rr_data_next_r <= rr_data_next_r;
    end
  end
`else
  assign grant_data_s = d_req_i;
`endif

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_s      = state_r;
    owner_data_s = owner_data_r;
    iswr_s       = iswr_r;
    base_s       = base_r;
    last_s       = last_r;
    k_s          = k_r;
    wdata_s      = wdata_r;
    rdata_s      = rdata_r;
    m_valid_s    = 1'b0;
    m_iswr_s     = m_iswr_o;
    m_addr_s     = m_addr_o;
    m_data_s     = m_data_o;
    if_ack_s     = 1'b0;
    d_ack_s      = 1'b0;
    if_data_s    = if_data_o;
    d_rdata_s    = d_rdata_o;
    case (state_r)
      ST_IDLE: begin
        if (if_req_i || d_req_i) begin
          owner_data_s = grant_data_s;
          if (grant_data_s) begin
            iswr_s  = d_we_i;
            base_s  = d_addr_i;
            last_s  = data_last(d_size_i);
            wdata_s = d_we_i ? d_wdata_i : 32'd0;
          end else begin
            iswr_s  = 1'b0;
            base_s  = if_addr_i;
            last_s  = FETCH_LAST;
            wdata_s = 32'd0;
          end
          rdata_s   = 32'd0;
          k_s       = 2'd0;
          state_s   = ST_ISSUE;
          m_valid_s = 1'b1;
          m_iswr_s  = iswr_s;
          m_addr_s  = base_s;
          m_data_s  = byte_lane(wdata_s, 2'd0);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (m_done_i) begin
          rdata_s = iswr_r ? rdata_r : merge_byte(rdata_r, k_r, m_data_i);
          state_s = ST_GAP;
          // The ack is registered so it lands in the final GAP cycle.
          if (k_r == last_r) begin
            if (owner_data_r) begin
              d_ack_s   = 1'b1;
              d_rdata_s = rdata_s;
            end else begin
              if_ack_s  = 1'b1;
              if_data_s = rdata_s;
            end
          end else begin
            state_s = ST_GAP;
          end
        end else begin
          m_valid_s = 1'b1;
        end
      end
      ST_GAP: begin
        if (k_r == last_r) begin
          state_s = ST_IDLE;
        end else begin
          k_s       = k_r + 2'd1;
          state_s   = ST_ISSUE;
          m_valid_s = 1'b1;
          m_addr_s  = base_r + {14'd0, k_s};
          m_data_s  = byte_lane(wdata_r, k_s);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, transfer context and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      owner_data_r <= 1'b0;
      iswr_r       <= 1'b0;
      base_r       <= 16'd0;
      last_r       <= 2'd0;
      k_r          <= 2'd0;
      wdata_r      <= 32'd0;
      rdata_r      <= 32'd0;
      m_valid_o    <= 1'b0;
      m_iswr_o     <= 1'b0;
      m_addr_o     <= 16'd0;
      m_data_o     <= 8'd0;
      if_ack_o     <= 1'b0;
      d_ack_o      <= 1'b0;
      if_data_o    <= 32'd0;
      d_rdata_o    <= 32'd0;
    end else begin
      state_r      <= state_s;
      owner_data_r <= owner_data_s;
      iswr_r       <= iswr_s;
      base_r       <= base_s;
      last_r       <= last_s;
      k_r          <= k_s;
      wdata_r      <= wdata_s;
      rdata_r      <= rdata_s;
      m_valid_o    <= m_valid_s;
      m_iswr_o     <= m_iswr_s;
      m_addr_o     <= m_addr_s;
      m_data_o     <= m_data_s;
      if_ack_o     <= if_ack_s;
      d_ack_o      <= d_ack_s;
      if_data_o    <= if_data_s;
      d_rdata_o    <= d_rdata_s;
    end
  end
endmodule

// File: tb/tb_dumbrv_spi_arb.sv
// Randomised bench for dumbrv_spi_arb: a byte-controller responder plus a request-level
// reference model that predicts the issued byte stream, ack order and returned data.
module tb_dumbrv_spi_arb;
  localparam int FETCH_BYTES = 4;
`ifdef DUMBRV_SPI_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_i, d_req_i, d_we_i;
  logic [15:0] if_addr_i, d_addr_i;
  logic [1:0]  d_size_i;
  logic [31:0] d_wdata_i;
  logic        if_ack_o, d_ack_o;
  logic [31:0] if_data_o, d_rdata_o;
  logic        m_valid_o, m_iswr_o;
  logic [15:0] m_addr_o;
  logic [7:0]  m_data_o;
  logic        m_done_i;
  logic [7:0]  m_data_i;

  dumbrv_spi_arb #(.FETCH_BYTES(FETCH_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_data_o(if_data_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_size_i(d_size_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o),
    .m_valid_o(m_valid_o), .m_iswr_o(m_iswr_o), .m_addr_o(m_addr_o), .m_data_o(m_data_o),
    .m_done_i(m_done_i), .m_data_i(m_data_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        dport;
    logic        we;
    logic [1:0]  size;
    logic [15:0] addr;
    logic [31:0] wdata;
  } req_t;
  typedef struct packed {
    logic [15:0] addr;
    logic        iswr;
    logic [7:0]  data;
  } byte_t;
  typedef struct packed {
    logic        dport;
    logic        chk;
    logic [31:0] data;
  } ack_t;

  req_t  if_q[$];
  req_t  d_q[$];
  byte_t exp_b[$];
  ack_t  exp_a[$];
  logic [7:0] ref_mem  [logic [15:0]];
  logic [7:0] ctrl_mem [logic [15:0]];
  bit    rr_data_next = 1'b0;
  int    n_checks = 0;
  int    n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic req_t mk_req(input logic dport, input logic we, input logic [1:0] size,
                                  input logic [15:0] addr, input logic [31:0] wdata);
    req_t r;
    r.dport = dport; r.we = we; r.size = size; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 2))
      0:       return 16'hFFFC + 16'($urandom_range(0, 3));
      1:       return 16'h4000 + 16'($urandom_range(0, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  // Controller model: answers each m_valid after 0..3 cycles, holds done until valid drops.
  initial begin : responder
    int delay = 0;
    m_done_i = 1'b0;
    m_data_i = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_done_i = 1'b0;
        delay = 0;
      end else if (!m_valid_o) begin
        m_done_i = 1'b0;
        m_data_i = 8'($urandom);
        delay = $urandom_range(0, 3);
      end else if (!m_done_i) begin
        if (delay == 0) begin
          m_done_i = 1'b1;
          if (m_iswr_o) ctrl_mem[m_addr_o] = m_data_o;
          else m_data_i = ctrl_mem.exists(m_addr_o) ? ctrl_mem[m_addr_o] : init_byte(m_addr_o);
        end else begin
          delay--;
        end
      end
    end
  end

  // Reference: serve pending requests one at a time, choosing between two waiting heads by policy.
  task automatic model_batch();
    int fi = 0;
    int di = 0;
    while (fi < if_q.size() || di < d_q.size()) begin
      req_t r;
      bit pick_d;
      int n;
      logic [31:0] word;
      ack_t a;
      if (fi < if_q.size() && di < d_q.size()) pick_d = RR_EN ? rr_data_next : 1'b1;
      else pick_d = (di < d_q.size());
      if (pick_d) begin
        r = d_q[di]; di++;
        n = 1 << ((r.size > 2'd2) ? 2 : int'(r.size));
      end else begin
        r = if_q[fi]; fi++;
        n = FETCH_BYTES;
      end
      rr_data_next = !pick_d;
      word = 32'd0;
      for (int i = 0; i < n; i++) begin
        logic [15:0] ba = r.addr + 16'(i);
        byte_t eb;
        eb.addr = ba;
        eb.iswr = r.we;
        eb.data = r.we ? r.wdata[8*i +: 8] : 8'h00;
        if (r.we) ref_mem[ba] = eb.data;
        else word[8*i +: 8] = ref_rd(ba);
        exp_b.push_back(eb);
      end
      a.dport = pick_d;
      a.chk = !r.we;
      a.data = word;
      exp_a.push_back(a);
    end
  endtask

  task automatic drive_heads();
    if_req_i = (if_q.size() > 0);
    if_addr_i = (if_q.size() > 0) ? if_q[0].addr : 16'h0000;
    d_req_i = (d_q.size() > 0);
    d_we_i = (d_q.size() > 0) ? d_q[0].we : 1'b0;
    d_size_i = (d_q.size() > 0) ? d_q[0].size : 2'd0;
    d_addr_i = (d_q.size() > 0) ? d_q[0].addr : 16'h0000;
    d_wdata_i = (d_q.size() > 0) ? d_q[0].wdata : 32'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rr_data_next = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_batch(input int budget);
    int cycles = 0;
    int low_run = 0;
    bit prev_v = 1'b0;
    bit seen_byte = 1'b0;
    model_batch();
    drive_heads();
    while (exp_a.size() > 0 && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (m_valid_o && !prev_v) begin
        if (seen_byte) check_eq("gap_len", low_run, 1);
        if (exp_b.size() == 0) begin
          check_eq("extra_byte_addr", m_addr_o, 32'hFFFF_FFFF);
        end else begin
          byte_t e = exp_b.pop_front();
          check_eq("m_addr", m_addr_o, e.addr);
          check_eq("m_iswr", m_iswr_o, e.iswr);
          check_eq("m_data", m_data_o, e.data);
        end
        seen_byte = 1'b1;
        low_run = 0;
      end
      if (!m_valid_o) low_run++;
      if (if_ack_o || d_ack_o) begin
        ack_t ea = exp_a.pop_front();
        check_eq("single_ack", {if_ack_o, d_ack_o} == 2'b11, 0);
        check_eq("ack_port", d_ack_o, ea.dport);
        check_eq("ack_in_final_gap", low_run, 1);
        if (ea.chk) check_eq("rdata", d_ack_o ? d_rdata_o : if_data_o, ea.data);
        if (d_ack_o && d_q.size() > 0) void'(d_q.pop_front());
        else if (if_ack_o && if_q.size() > 0) void'(if_q.pop_front());
        drive_heads();
        seen_byte = 1'b0;
      end
      prev_v = m_valid_o;
    end
    if (exp_a.size() != 0) begin
      check_eq("ack_timeout", exp_a.size(), 0);
      exp_a.delete(); exp_b.delete(); if_q.delete(); d_q.delete();
      drive_heads();
      do_reset();
    end else begin
      check_eq("bytes_left", exp_b.size(), 0);
      @(negedge clk);
      check_eq("idle_after_ack", {29'd0, if_ack_o, d_ack_o, m_valid_o}, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive_heads();
    repeat (3) @(negedge clk);
    check_eq("rst_valid_iswr", {m_valid_o, m_iswr_o}, 0);
    check_eq("rst_addr_data", {m_addr_o, m_data_o}, 0);
    check_eq("rst_acks", {if_ack_o, d_ack_o}, 0);
    check_eq("rst_if_data", if_data_o, 0);
    check_eq("rst_d_rdata", d_rdata_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Seed 0x100..0x103 with 11 22 33 44, then fetch it back.
    d_q.push_back(mk_req(1'b1, 1'b1, 2'd2, 16'h0100, 32'h4433_2211));
    run_batch(200);
    if_q.push_back(mk_req(1'b0, 1'b0, 2'd0, 16'h0100, 32'd0));
    run_batch(200);
    // Halfword store: only DD and CC may be issued.
    d_q.push_back(mk_req(1'b1, 1'b1, 2'd1, 16'h2000, 32'hAABB_CCDD));
    run_batch(200);
    // Byte at 0xFFFF, then a word load wrapping through 0x0000.
    d_q.push_back(mk_req(1'b1, 1'b1, 2'd0, 16'hFFFF, 32'h0000_005A));
    d_q.push_back(mk_req(1'b1, 1'b0, 2'd0, 16'hFFFF, 32'd0));
    d_q.push_back(mk_req(1'b1, 1'b0, 2'd3, 16'hFFFE, 32'd0));
    run_batch(300);
    // Simultaneous requests with the data port requesting twice in a row.
    if_q.push_back(mk_req(1'b0, 1'b0, 2'd0, 16'h0100, 32'd0));
    d_q.push_back(mk_req(1'b1, 1'b0, 2'd1, 16'h2000, 32'd0));
    d_q.push_back(mk_req(1'b1, 1'b0, 2'd2, 16'h0101, 32'd0));
    run_batch(400);

    // Reset during the second byte of a fetch.
    begin
      int rises = 0;
      int cyc = 0;
      bit pv = 1'b0;
      if_req_i = 1'b1;
      if_addr_i = 16'h0300;
      while (rises < 2 && cyc < 200) begin
        @(negedge clk);
        cyc++;
        if (m_valid_o && !pv) rises++;
        pv = m_valid_o;
      end
      check_eq("reach_byte2", rises, 2);
      rst_n = 1'b0;
      if_req_i = 1'b0;
      rr_data_next = 1'b0;
      @(posedge clk);
      #1;
      check_eq("midrst_valid", {m_valid_o, m_iswr_o, if_ack_o, d_ack_o}, 0);
      check_eq("midrst_addr_data", {m_addr_o, m_data_o}, 0);
      check_eq("midrst_if_data", if_data_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      if_q.push_back(mk_req(1'b0, 1'b0, 2'd0, 16'h0300, 32'd0));
      run_batch(200);
    end

    // Randomised batches mixing both ports, sizes and wrap-prone addresses.
    for (int b = 0; b < 40; b++) begin
      int nf = $urandom_range(0, 2);
      int nd = $urandom_range(0, 2);
      if (nf + nd == 0) nd = 1;
      for (int i = 0; i < nf; i++) if_q.push_back(mk_req(1'b0, 1'b0, 2'd0, rand_addr(), 32'd0));
      for (int i = 0; i < nd; i++)
        d_q.push_back(mk_req(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                             rand_addr(), $urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_batch(600);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
